cart_bus_initiator: RTL and testbench
=====================================

// Module: cart_bus_initiator
// PURPOSE
//  Initiator (master) end of the cart register bus (request/write/busy/ack).
//  Turns one host command (valid/ready) into one bus transaction toward a
//  register responder. Returns exactly one response per command, in order.
//  Sits between the command decoder and the cart register blocks.
// PARAMETERS
//  ADDRESS_WIDTH   4     width of bus/command address
//  TIMEOUT_CYCLES  255   max cycles from request assert to completion (>=2)
// PORTS
//  i_clk          in   1   system clock
//  i_reset        in   1   synchronous, active-high reset
//  i_cmd_valid    in   1   host command valid
//  o_cmd_ready    out  1   initiator can accept command
//  i_cmd_write    in   1   1=write, 0=read
//  i_cmd_address  in   AW  register address
//  i_cmd_data     in   32  write data
//  o_rsp_valid    out  1   response valid
//  i_rsp_ready    in   1   host takes response
//  o_rsp_data     out  32  read data (0 for writes/errors)
//  o_rsp_error    out  1   1=transaction timed out
//  o_request      out  1   bus request
//  o_write        out  1   bus write qualifier
//  o_address      out  AW  bus address
//  o_data         out  32  bus write data
//  i_busy         in   1   responder stall
//  i_ack          in   1   read data valid (one cycle)
//  i_data         in   32  read data from responder
// BEHAVIOUR
//  Reset: state IDLE; o_cmd_ready=1, o_request=0, o_rsp_valid=0;
//   o_write/o_address/o_data/o_rsp_data/o_rsp_error=0; timeout counter 0.
//  Bus rule: a transfer is accepted on a clock edge where o_request && !i_busy.
//   For reads, responder asserts i_ack one or more cycles after acceptance.
//   Writes get no ack. All bus outputs are registered.
//  FSM:
//  IDLE: o_cmd_ready=1 (combinational from state). On i_cmd_valid: latch
//   write/address/data onto o_write/o_address/o_data, set o_request=1,
//   clear counter -> REQUEST.
//  REQUEST: o_request held with stable o_write/o_address/o_data while i_busy.
//   Counter++ each cycle. If !i_busy: o_request<=0; write -> RESPONSE with
//   rsp_data=0, error=0; read -> WAIT_ACK.
//  WAIT_ACK: o_request=0. Counter++. On i_ack: o_rsp_data<=i_data,
//   error=0 -> RESPONSE.
//  Timeout: in REQUEST/WAIT_ACK, counter reaching TIMEOUT_CYCLES-1 without
//   completion -> o_request<=0, o_rsp_data<=0, o_rsp_error<=1 -> RESPONSE.
//   Completion (!i_busy in REQUEST, i_ack in WAIT_ACK) on the same cycle
//   wins over timeout.
//  RESPONSE: o_rsp_valid=1, data/error stable until i_rsp_ready -> IDLE
//   (o_rsp_valid drops next cycle). o_cmd_ready=0 until back in IDLE.
//  i_ack outside WAIT_ACK is ignored. Counter width $clog2(TIMEOUT_CYCLES+1),
//   saturating, no wrap.
//  Latency (i_busy=0, immediate ack): write cmd accept -> rsp_valid 2 cycles;
//   read -> 3 cycles. Max one transaction outstanding.
//  Reset mid-transaction: o_request drops at the reset edge; the pending
//   response is discarded; no partial response is emitted.
// TESTING
//  1 Write addr 0 data 0x0000_001A, busy=0 -> o_request high exactly 1
//    cycle, o_write=1, o_data=0x1A; rsp_valid, data 0, error 0.
//  2 Read addr 1, responder acks next cycle with 0xDEAD_BEEF ->
//    rsp_data=0xDEAD_BEEF, error 0; o_request high exactly 1 cycle.
//  3 Write with i_busy high 5 cycles -> request/addr/data held stable
//    6 cycles, single acceptance, error 0.
//  4 Read, no ack, TIMEOUT_CYCLES=8 -> rsp_valid with error 1, data 0,
//    8 cycles after o_request rose; late i_ack afterward ignored.
//  5 i_rsp_ready held low 10 cycles -> response stable, o_cmd_ready=0,
//    new i_cmd_valid not accepted; back-to-back 3 commands -> in-order rsps.
//  6 i_reset asserted while in REQUEST with i_busy=1 -> next cycle
//    o_request=0, o_rsp_valid=0, o_cmd_ready=1.

Source files
------------

// File: rtl/cart_bus_initiator.sv
// Initiator end of the cart register bus: turns one host command into one
// request/busy/ack bus transaction and returns exactly one response.
module cart_bus_initiator #(
  parameter int ADDRESS_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic                     i_cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] i_cmd_address,
  input  logic [31:0]              i_cmd_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_data,
  output logic                     o_rsp_error,
  output logic                     o_request,
  output logic                     o_write,
  output logic [ADDRESS_WIDTH-1:0] o_address,
  output logic [31:0]              o_data,
  input  logic                     i_busy,
  input  logic                     i_ack,
  input  logic [31:0]              i_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_WAIT_ACK,
    S_RESPONSE
  } state_t;

  state_t                   r_state, w_state_next;
  logic                     r_request, w_request_next;
  logic                     r_write, w_write_next;
  logic [ADDRESS_WIDTH-1:0] r_address, w_address_next;
  logic [31:0]              r_data, w_data_next;
  logic [31:0]              r_rsp_data, w_rsp_data_next;
  logic                     r_rsp_error, w_rsp_error_next;
  logic [CW-1:0]            r_count, w_count_next;
  logic [CW-1:0]            w_count_inc;
  logic                     w_timeout;

  // Counter saturates rather than wrapping so a stuck value can never alias 0.
  assign w_count_inc = (r_count == {CW{1'b1}}) ? r_count : r_count + CW'(1);
  assign w_timeout   = (r_count == TIMEOUT_LAST);

  always_comb begin
    w_state_next     = r_state;
    w_request_next   = r_request;
    w_write_next     = r_write;
    w_address_next   = r_address;
    w_data_next      = r_data;
    w_rsp_data_next  = r_rsp_data;
    w_rsp_error_next = r_rsp_error;
    w_count_next     = r_count;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_write_next   = i_cmd_write;
          w_address_next = i_cmd_address;
          w_data_next    = i_cmd_data;
          w_request_next = 1'b1;
          w_count_next   = '0;
          w_state_next   = S_REQUEST;
        end
      end
      S_REQUEST: begin
        w_count_next = w_count_inc;
        // Acceptance is checked before timeout so completion wins a tie.
        if (!i_busy) begin
          w_request_next = 1'b0;
          if (r_write) begin
            w_rsp_data_next  = '0;
            w_rsp_error_next = 1'b0;
            w_state_next     = S_RESPONSE;
          end else begin
            w_state_next = S_WAIT_ACK;
          end
        end else if (w_timeout) begin
          w_request_next   = 1'b0;
          w_rsp_data_next  = '0;
          w_rsp_error_next = 1'b1;
          w_state_next     = S_RESPONSE;
        end
      end
      S_WAIT_ACK: begin
        w_count_next = w_count_inc;
        if (i_ack) begin
          w_rsp_data_next  = i_data;
          w_rsp_error_next = 1'b0;
          w_state_next     = S_RESPONSE;
        end else if (w_timeout) begin
          w_rsp_data_next  = '0;
          w_rsp_error_next = 1'b1;
          w_state_next     = S_RESPONSE;
        end
      end
      S_RESPONSE: begin
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_request   <= 1'b0;
      r_write     <= 1'b0;
      r_address   <= '0;
      r_data      <= '0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_request   <= w_request_next;
      r_write     <= w_write_next;
      r_address   <= w_address_next;
      r_data      <= w_data_next;
      r_rsp_data  <= w_rsp_data_next;
      r_rsp_error <= w_rsp_error_next;
      r_count     <= w_count_next;
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = (r_state == S_RESPONSE);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_error = r_rsp_error;
  assign o_request   = r_request;
  assign o_write     = r_write;
  assign o_address   = r_address;
  assign o_data      = r_data;

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Directed bench for cart_bus_initiator: hand-computed latencies, request
// widths, response payloads, timeout boundaries and reset behaviour.
module tb_cart_bus_initiator;

  localparam int AW = 4;
  localparam int TO = 8;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [AW-1:0] i_cmd_address;
  logic [31:0]   i_cmd_data;
  logic          o_rsp_valid;
  logic          i_rsp_ready;
  logic [31:0]   o_rsp_data;
  logic          o_rsp_error;
  logic          o_request;
  logic          o_write;
  logic [AW-1:0] o_address;
  logic [31:0]   o_data;
  logic          i_busy;
  logic          i_ack;
  logic [31:0]   i_data;

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;

  always #5 i_clk = ~i_clk;

  cart_bus_initiator #(
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_write  (i_cmd_write),
    .i_cmd_address(i_cmd_address),
    .i_cmd_data   (i_cmd_data),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_error  (o_rsp_error),
    .o_request    (o_request),
    .o_write      (o_write),
    .o_address    (o_address),
    .o_data       (o_data),
    .i_busy       (i_busy),
    .i_ack        (i_ack),
    .i_data       (i_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Issue one command, play the responder, then drain the response.
  // Sample index k counts edges after the command-accept edge.
  task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input int busy_cycles, input int ack_at, input logic [31:0] ack_data,
                         input int hold, input int exp_lat, input int exp_req,
                         input logic [31:0] exp_data, input logic exp_err);
    int          lat;
    int          req_cycles;
    logic        stable_ok;
    logic        hold_ok;
    logic [31:0] got_data;
    logic        got_err;
    lat        = -1;
    req_cycles = 0;
    stable_ok  = 1'b1;
    hold_ok    = 1'b1;
    check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid   = 1'b1;
    i_cmd_write   = wr;
    i_cmd_address = addr;
    i_cmd_data    = wdata;
    i_busy        = 1'b0;
    i_ack         = 1'b0;
    tick;
    i_cmd_valid   = 1'b0;
    i_cmd_write   = ~wr;
    i_cmd_address = ~addr;
    i_cmd_data    = ~wdata;
    for (int k = 0; k < 40; k++) begin
      if (o_rsp_valid) begin
        lat = k;
        break;
      end
      if (o_request) begin
        req_cycles++;
        if (o_write !== wr || o_address !== addr || o_data !== wdata) stable_ok = 1'b0;
      end
      i_busy = (k < busy_cycles);
      i_ack  = (k == ack_at);
      i_data = (k == ack_at) ? ack_data : 32'h5555_0000;
      tick;
    end
    i_busy   = 1'b0;
    i_ack    = 1'b0;
    got_data = o_rsp_data;
    got_err  = o_rsp_error;
    check("latency", 32'(lat), 32'(exp_lat));
    check("req_cycles", 32'(req_cycles), 32'(exp_req));
    check("bus_stable", 32'(stable_ok), 32'd1);
    check("rsp_data", got_data, exp_data);
    check("rsp_error", 32'(got_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      i_cmd_valid = 1'b1;
      i_cmd_write = 1'b1;
      tick;
      if (!o_rsp_valid || o_rsp_data !== got_data || o_rsp_error !== got_err
          || o_cmd_ready || o_request) hold_ok = 1'b0;
    end
    i_cmd_valid = 1'b0;
    if (hold > 0) check("rsp_hold", 32'(hold_ok), 32'd1);
    i_rsp_ready = 1'b1;
    tick;
    i_rsp_ready = 1'b0;
    check("rsp_drop", 32'(o_rsp_valid), 32'd0);
    check("ready_back", 32'(o_cmd_ready), 32'd1);
    i_ack  = 1'b1;
    i_data = 32'hBAD0_BAD0;
    tick;
    i_ack  = 1'b0;
    check("late_ack_ignored", 32'({o_rsp_valid, o_request, o_cmd_ready}), 32'b001);
    n_txn++;
    $display("txn %0d: wr=%0b addr=%h lat=%0d req=%0d data=%h err=%0b",
             n_txn, wr, addr, lat, req_cycles, got_data, got_err);
  endtask

  initial begin
    i_reset       = 1'b1;
    i_cmd_valid   = 1'b0;
    i_cmd_write   = 1'b0;
    i_cmd_address = '0;
    i_cmd_data    = '0;
    i_rsp_ready   = 1'b0;
    i_busy        = 1'b0;
    i_ack         = 1'b0;
    i_data        = '0;
    tick;
    tick;
    i_reset = 1'b0;
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_request", 32'(o_request), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_write", 32'(o_write), 32'd0);
    check("rst_address", 32'(o_address), 32'd0);
    check("rst_data", o_data, 32'd0);
    check("rst_rsp_data", o_rsp_data, 32'd0);
    check("rst_rsp_error", 32'(o_rsp_error), 32'd0);

    //      wr    addr   wdata          busy ack  ackdata        hold lat req exp_data       err
    run_cmd(1'b1, 4'h0, 32'h0000_001A,   0,  -1, 32'h0,           0,  1,  1, 32'h0,         1'b0);
    run_cmd(1'b0, 4'h1, 32'h0,           0,   1, 32'hDEAD_BEEF,   0,  2,  1, 32'hDEAD_BEEF, 1'b0);
    run_cmd(1'b1, 4'h2, 32'hCAFE_0003,   5,  -1, 32'h0,           0,  6,  6, 32'h0,         1'b0);
    run_cmd(1'b0, 4'h3, 32'h0,           0,  -1, 32'h0,           0,  8,  1, 32'h0,         1'b1);
    run_cmd(1'b0, 4'h4, 32'h0,         100,  -1, 32'h0,           0,  8,  8, 32'h0,         1'b1);
    run_cmd(1'b1, 4'h5, 32'h0000_0055,   7,  -1, 32'h0,           0,  8,  8, 32'h0,         1'b0);
    run_cmd(1'b0, 4'h6, 32'h0,           0,   7, 32'h1234_5678,   0,  8,  1, 32'h1234_5678, 1'b0);
    run_cmd(1'b0, 4'h7, 32'h0,           0,   1, 32'hA5A5_A5A5,  10,  2,  1, 32'hA5A5_A5A5, 1'b0);
    run_cmd(1'b1, 4'h8, 32'h0000_0808,   0,  -1, 32'h0,           0,  1,  1, 32'h0,         1'b0);
    run_cmd(1'b0, 4'h9, 32'h0,           0,   3, 32'h0909_0909,   0,  4,  1, 32'h0909_0909, 1'b0);
    run_cmd(1'b1, 4'hA, 32'h0A0A_0A0A,   2,  -1, 32'h0,           0,  3,  3, 32'h0,         1'b0);

    // Reset while a write is stalled in the request phase.
    i_cmd_valid   = 1'b1;
    i_cmd_write   = 1'b1;
    i_cmd_address = 4'hF;
    i_cmd_data    = 32'h0F0F_0F0F;
    i_busy        = 1'b1;
    tick;
    i_cmd_valid = 1'b0;
    tick;
    check("pre_reset_request", 32'(o_request), 32'd1);
    i_reset = 1'b1;
    tick;
    check("mid_rst_request", 32'(o_request), 32'd0);
    check("mid_rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    i_reset = 1'b0;
    i_busy  = 1'b0;
    tick;
    tick;
    check("post_rst_no_rsp", 32'({o_rsp_valid, o_request}), 32'd0);
    $display("txn %0d: reset during stalled request", n_txn + 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
